// File: rtl/npr_master_if.sv
// Unibus signal bundle between an NPR bus master and the rest of the bus:
// arbitration, master/slave sync handshake, address, cycle type and data.
interface npr_master_if;
  logic        init_in_h;
  logic        npg_in_h;
  logic        bbsy_in_h;
  logic        ssyn_in_h;
  logic [15:0] d_in_h;
  logic        npr_out_h;
  logic        sack_out_h;
  logic        bbsy_out_h;
  logic [17:0] a_out_h;
  logic [1:0]  c_out_h;
  logic [15:0] d_out_h;
  logic        msyn_out_h;

  modport master (
    input  init_in_h, npg_in_h, bbsy_in_h, ssyn_in_h, d_in_h,
    output npr_out_h, sack_out_h, bbsy_out_h, a_out_h, c_out_h, d_out_h, msyn_out_h
  );

  modport slave (
    output init_in_h, npg_in_h, bbsy_in_h, ssyn_in_h, d_in_h,
    input  npr_out_h, sack_out_h, bbsy_out_h, a_out_h, c_out_h, d_out_h, msyn_out_h
  );
endinterface

// File: rtl/npr_master.sv
// Unibus NPR bus master: the ARM loads address/cycle/data and starts one
// DATI/DATO/DATOB transfer; the block arbitrates, runs the cycle, reports status.
module npr_master #(
  parameter int DESKEW  = 15,
  parameter int TIMEOUT = 1000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  input  logic [1:0]  armraddr,
  output logic [31:0] armrdata,
  output logic        armintrq,
  npr_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_GRANT, S_DESKEW, S_MSYN, S_RELEASE, S_FINISH
  } state_t;

  localparam logic [16:0] DESKEW_LIM  = 17'(DESKEW);
  localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT);

  state_t      state, state_next;
  logic [15:0] cnt;
  logic [16:0] cnt_inc;
  logic        busy, done, tmo;
  logic [17:0] a;
  logic [1:0]  c;
  logic [15:0] wdata, rdata;
  logic        reg1_write, start, abort, drive;
  logic        req_timeout, msyn_timeout, latch_rdata, finish;
  logic        unused_wdata_bits;

  assign unused_wdata_bits = ^armwdata[28:18];
  assign cnt_inc  = {1'b0, cnt} + 17'd1;
  assign drive    = (state == S_DESKEW) || (state == S_MSYN) || (state == S_RELEASE);
  assign armintrq = done;

  always_comb begin
    state_next   = state;
    req_timeout  = 1'b0;
    msyn_timeout = 1'b0;
    latch_rdata  = 1'b0;
    finish       = 1'b0;
    abort        = bus.init_in_h && (state != S_IDLE);
    // A start request coinciding with INIT is dropped as a whole.
    reg1_write   = armwrite && (armwaddr == 2'd1) && !(bus.init_in_h && armwdata[31]);
    start        = reg1_write && !busy && armwdata[31];
    unique case (state)
      S_IDLE:    if (start) state_next = S_REQ;
      S_REQ: begin
        if (bus.npg_in_h) begin
          state_next = S_GRANT;
        end else if (cnt_inc >= TIMEOUT_LIM) begin
          req_timeout = 1'b1;
          state_next  = S_IDLE;
        end
      end
      S_GRANT:   if (!bus.npg_in_h && !bus.bbsy_in_h && !bus.ssyn_in_h) state_next = S_DESKEW;
      S_DESKEW:  if (cnt_inc >= DESKEW_LIM) state_next = S_MSYN;
      S_MSYN: begin
        if (bus.ssyn_in_h) begin
          latch_rdata = !c[1];
          state_next  = S_RELEASE;
        end else if (cnt_inc >= TIMEOUT_LIM) begin
          msyn_timeout = 1'b1;
          state_next   = S_RELEASE;
        end
      end
      S_RELEASE: if (!bus.ssyn_in_h || tmo) state_next = S_FINISH;
      S_FINISH: begin
        finish     = 1'b1;
        state_next = S_IDLE;
      end
      default:   state_next = S_IDLE;
    endcase
    if (abort) begin
      state_next   = S_IDLE;
      req_timeout  = 1'b0;
      msyn_timeout = 1'b0;
      latch_rdata  = 1'b0;
      finish       = 1'b0;
    end
  end

  // One shared counter times the grant wait, the deskew and the ssyn wait;
  // it restarts on every state change and saturates instead of wrapping.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) cnt <= '0;
      else if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      tmo   <= 1'b0;
      a     <= '0;
      c     <= '0;
      wdata <= '0;
      rdata <= '0;
    end else begin
      if (reg1_write) done <= 1'b0;
      if (reg1_write && !busy) begin
        a <= armwdata[17:0];
        c <= armwdata[30:29];
      end
      if (start) begin
        busy <= 1'b1;
        tmo  <= 1'b0;
      end
      if (armwrite && (armwaddr == 2'd3) && !busy) wdata <= armwdata[15:0];
      if (latch_rdata) rdata <= bus.d_in_h;
      if (msyn_timeout) tmo <= 1'b1;
      if (req_timeout || abort) begin
        tmo  <= 1'b1;
        done <= 1'b1;
        busy <= 1'b0;
      end
      if (finish) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

  // Bus outputs follow the state one clock later, except that INIT clears them at once.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      bus.npr_out_h  <= 1'b0;
      bus.sack_out_h <= 1'b0;
      bus.bbsy_out_h <= 1'b0;
      bus.msyn_out_h <= 1'b0;
      bus.a_out_h    <= '0;
      bus.c_out_h    <= '0;
      bus.d_out_h    <= '0;
    end else if (abort) begin
      bus.npr_out_h  <= 1'b0;
      bus.sack_out_h <= 1'b0;
      bus.bbsy_out_h <= 1'b0;
      bus.msyn_out_h <= 1'b0;
      bus.a_out_h    <= '0;
      bus.c_out_h    <= '0;
      bus.d_out_h    <= '0;
    end else begin
      bus.npr_out_h  <= (state == S_REQ);
      bus.sack_out_h <= (state == S_GRANT);
      bus.bbsy_out_h <= drive;
      bus.msyn_out_h <= (state == S_MSYN);
      bus.a_out_h    <= drive ? a : '0;
      bus.c_out_h    <= drive ? c : '0;
      bus.d_out_h    <= (drive && c[1]) ? wdata : '0;
    end
  end

  // Status word packs c just above the 18-bit address so all fields fit in 32 bits.
  always_comb begin
    armrdata = '0;
    unique case (armraddr)
      2'd0: armrdata = 32'h4E501001;
      2'd1: armrdata = {busy, done, tmo, 9'b0, c, a};
      2'd2: armrdata = {16'b0, rdata};
      2'd3: armrdata = {16'b0, wdata};
      default: armrdata = '0;
    endcase
  end

endmodule

// File: tb/tb_npr_master.sv
// Directed bench for npr_master: plays ARM, arbiter and slave; bus cycles and
// completion status are checked by a monitor against queued expectations.
`timescale 1ns/1ps
module tb_npr_master;
  localparam int DESKEW  = 4;
  localparam int TIMEOUT = 20;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        armwrite;
  logic [1:0]  armwaddr, armraddr;
  logic [31:0] armwdata, armrdata;
  logic        armintrq;

  npr_master_if bus_if ();

  npr_master #(.DESKEW(DESKEW), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .armwrite (armwrite),
    .armwaddr (armwaddr),
    .armwdata (armwdata),
    .armraddr (armraddr),
    .armrdata (armrdata),
    .armintrq (armintrq),
    .bus      (bus_if)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic [17:0] a;
    logic [1:0]  c;
    logic [15:0] d;
  } bus_exp_t;

  bus_exp_t   bus_q[$];
  logic [2:0] status_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] busOut();
    return {24'b0, bus_if.npr_out_h, bus_if.sack_out_h, bus_if.bbsy_out_h, bus_if.msyn_out_h,
            bus_if.a_out_h, bus_if.c_out_h, bus_if.d_out_h};
  endfunction

  task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
    armwaddr = addr;
    armwdata = data;
    armwrite = 1'b1;
    @(posedge CLOCK); #1;
    armwrite = 1'b0;
  endtask

  task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
    @(posedge CLOCK); #1;
    armraddr = addr;
    #1 data = armrdata;
    armraddr = 2'd1;
  endtask

  // Arbiter: grants `delay` cycles after seeing npr, expects sack two edges later.
  task automatic grantBus(input int delay);
    int n;
    n = 0;
    while (!bus_if.npr_out_h && n < 50) begin @(negedge CLOCK); n++; end
    checkOutput("npr_wait", 64'(bus_if.npr_out_h), 64'd1);
    repeat (delay) @(posedge CLOCK);
    #1 bus_if.npg_in_h = 1'b1;
    n = 0;
    do begin @(negedge CLOCK); n++; end while (!bus_if.sack_out_h && n < 50);
    checkOutput("sack_latency", 64'(n), 64'd3);
    @(posedge CLOCK); #1 bus_if.npg_in_h = 1'b0;
  endtask

  // Slave: raises ssyn on the third sample of msyn high (or never), and drops
  // it one cycle after msyn goes away. Returns the msyn high time in cycles.
  task automatic slaveCycle(input bit respond, input logic [15:0] data, output int msyn_len);
    int n;
    msyn_len = 0;
    n = 0;
    while (!bus_if.msyn_out_h && n < 100) begin @(negedge CLOCK); n++; end
    checkOutput("msyn_wait", 64'(bus_if.msyn_out_h), 64'd1);
    while (bus_if.msyn_out_h && msyn_len < 2 * TIMEOUT) begin
      msyn_len++;
      if (respond && msyn_len == 3) begin
        bus_if.d_in_h    = data;
        bus_if.ssyn_in_h = 1'b1;
      end
      @(negedge CLOCK);
    end
    if (respond) begin
      @(negedge CLOCK);
      bus_if.ssyn_in_h = 1'b0;
      bus_if.d_in_h    = 16'h0;
    end
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    while (!armintrq && n < 100) begin @(negedge CLOCK); n++; end
    checkOutput(name, 64'(armintrq), 64'd1);
  endtask

  initial begin : monitor
    logic       prev_msyn, prev_intrq;
    int         deskew_cnt;
    bus_exp_t   e;
    logic [2:0] s;
    prev_msyn  = 1'b0;
    prev_intrq = 1'b0;
    deskew_cnt = 0;
    forever begin
      @(negedge CLOCK);
      if (bus_if.msyn_out_h && !prev_msyn) begin
        if (bus_q.size() == 0) checkOutput("unexpected_msyn", 64'd1, 64'd0);
        else begin
          e = bus_q.pop_front();
          checkOutput("bus_addr", 64'(bus_if.a_out_h), 64'(e.a));
          checkOutput("bus_cycle", 64'(bus_if.c_out_h), 64'(e.c));
          checkOutput("bus_wdata", 64'(bus_if.d_out_h), 64'(e.d));
          checkOutput("deskew_cycles", 64'(deskew_cnt), 64'(DESKEW));
        end
      end
      if (armintrq && !prev_intrq) begin
        if (status_q.size() == 0) checkOutput("unexpected_done", 64'd1, 64'd0);
        else begin
          s = status_q.pop_front();
          checkOutput("done_status", 64'(armrdata[31:29]), 64'(s));
        end
      end
      deskew_cnt = (bus_if.bbsy_out_h && !bus_if.msyn_out_h) ? deskew_cnt + 1 : 0;
      prev_msyn  = bus_if.msyn_out_h;
      prev_intrq = armintrq;
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] r;
    int len;
    int n;
    bit seen;
    RESET    = 1'b1;
    armwrite = 1'b0;
    armwaddr = 2'd0;
    armwdata = 32'h0;
    armraddr = 2'd1;
    bus_if.init_in_h = 1'b0;
    bus_if.npg_in_h  = 1'b0;
    bus_if.bbsy_in_h = 1'b0;
    bus_if.ssyn_in_h = 1'b0;
    bus_if.d_in_h    = 16'h0;
    repeat (2) @(posedge CLOCK);
    #1;
    checkOutput("reset_bus", busOut(), 64'd0);
    checkOutput("reset_intrq", 64'(armintrq), 64'd0);
    readReg(2'd1, r); checkOutput("reset_reg1", 64'(r), 64'd0);
    readReg(2'd0, r); checkOutput("id_reg", 64'(r), 64'h4E501001);
    @(posedge CLOCK); #1 RESET = 1'b0;

    $display("[TB] DATI read from 001000");
    bus_q.push_back(bus_exp_t'{a: 18'o001000, c: 2'b00, d: 16'h0});
    status_q.push_back(3'b010);
    applyStimulus(2'd1, {1'b1, 2'b00, 11'b0, 18'o001000});
    @(negedge CLOCK); checkOutput("npr_lag", 64'(bus_if.npr_out_h), 64'd0);
    @(negedge CLOCK); checkOutput("npr_asserted", 64'(bus_if.npr_out_h), 64'd1);
    grantBus(5);
    slaveCycle(1'b1, 16'o123456, len);
    checkOutput("dati_msyn_len", 64'(len), 64'd4);
    @(negedge CLOCK); checkOutput("done_lag_low", 64'(armintrq), 64'd0);
    @(negedge CLOCK); checkOutput("done_lag_high", 64'(armintrq), 64'd1);
    readReg(2'd2, r); checkOutput("dati_rdata", 64'(r), 64'h0000A72E);
    readReg(2'd1, r); checkOutput("dati_reg1", 64'(r), 64'h40000200);

    $display("[TB] DATO write 177777 to 774510");
    applyStimulus(2'd3, 32'h0000FFFF);
    bus_q.push_back(bus_exp_t'{a: 18'o774510, c: 2'b10, d: 16'hFFFF});
    status_q.push_back(3'b010);
    applyStimulus(2'd1, {1'b1, 2'b10, 11'b0, 18'o774510});
    checkOutput("write_clears_done", 64'(armintrq), 64'd0);
    grantBus(1);
    slaveCycle(1'b1, 16'h1234, len);
    checkOutput("dato_msyn_len", 64'(len), 64'd4);
    waitDone("dato_done");
    readReg(2'd2, r); checkOutput("dato_rdata_kept", 64'(r), 64'h0000A72E);
    readReg(2'd3, r); checkOutput("wdata_reg", 64'(r), 64'h0000FFFF);

    $display("[TB] no grant");
    status_q.push_back(3'b011);
    applyStimulus(2'd1, {1'b1, 2'b00, 11'b0, 18'o000100});
    len  = 0;
    seen = 1'b0;
    repeat (TIMEOUT + 10) begin
      @(negedge CLOCK);
      if (bus_if.npr_out_h) len++;
      if (bus_if.bbsy_out_h) seen = 1'b1;
    end
    checkOutput("npr_high_cycles", 64'(len), 64'(TIMEOUT));
    checkOutput("no_grant_bbsy", 64'(seen), 64'd0);
    checkOutput("no_grant_done", 64'(armintrq), 64'd1);

    $display("[TB] no slave");
    bus_q.push_back(bus_exp_t'{a: 18'o000200, c: 2'b00, d: 16'h0});
    status_q.push_back(3'b011);
    applyStimulus(2'd1, {1'b1, 2'b00, 11'b0, 18'o000200});
    grantBus(2);
    slaveCycle(1'b0, 16'h0, len);
    checkOutput("no_slave_msyn_len", 64'(len), 64'(TIMEOUT));
    @(negedge CLOCK);
    checkOutput("no_slave_release", busOut(), 64'd0);
    checkOutput("no_slave_done", 64'(armintrq), 64'd1);
    readReg(2'd2, r); checkOutput("no_slave_rdata_kept", 64'(r), 64'h0000A72E);

    $display("[TB] INIT abort during msyn");
    bus_q.push_back(bus_exp_t'{a: 18'o000400, c: 2'b00, d: 16'h0});
    status_q.push_back(3'b011);
    applyStimulus(2'd1, {1'b1, 2'b00, 11'b0, 18'o000400});
    applyStimulus(2'd1, {1'b1, 2'b11, 11'b0, 18'o000777});
    grantBus(1);
    n = 0;
    while (!bus_if.msyn_out_h && n < 100) begin @(negedge CLOCK); n++; end
    checkOutput("abort_msyn_seen", 64'(bus_if.msyn_out_h), 64'd1);
    @(posedge CLOCK); #1 bus_if.init_in_h = 1'b1;
    @(posedge CLOCK); #1 bus_if.init_in_h = 1'b0;
    @(negedge CLOCK);
    checkOutput("abort_bus_cleared", busOut(), 64'd0);
    checkOutput("abort_done", 64'(armintrq), 64'd1);
    readReg(2'd1, r); checkOutput("abort_reg1", 64'(r), 64'h60000100);

    $display("[TB] INIT while idle with a start write");
    @(posedge CLOCK); #1;
    bus_if.init_in_h = 1'b1;
    armwaddr = 2'd1;
    armwdata = {1'b1, 2'b10, 11'b0, 18'o000001};
    armwrite = 1'b1;
    @(posedge CLOCK); #1;
    bus_if.init_in_h = 1'b0;
    armwrite = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(negedge CLOCK); if (bus_if.npr_out_h) seen = 1'b1; end
    checkOutput("init_start_ignored", 64'(seen), 64'd0);
    readReg(2'd1, r); checkOutput("init_idle_reg1", 64'(r), 64'h60000100);
    readReg(2'd3, r); checkOutput("init_idle_wdata", 64'(r), 64'h0000FFFF);
    readReg(2'd2, r); checkOutput("init_idle_rdata", 64'(r), 64'h0000A72E);

    $display("[TB] async reset in deskew");
    applyStimulus(2'd1, {1'b1, 2'b10, 11'b0, 18'o001000});
    grantBus(1);
    n = 0;
    while (!bus_if.bbsy_out_h && n < 50) begin @(negedge CLOCK); n++; end
    checkOutput("deskew_bbsy", 64'(bus_if.bbsy_out_h), 64'd1);
    checkOutput("deskew_addr", 64'(bus_if.a_out_h), 64'(18'o001000));
    #1 RESET = 1'b1;
    #1;
    checkOutput("async_reset_bus", busOut(), 64'd0);
    checkOutput("async_reset_intrq", 64'(armintrq), 64'd0);
    checkOutput("async_reset_reg1", 64'(armrdata), 64'd0);
    @(posedge CLOCK); #1 RESET = 1'b0;
    repeat (3) @(negedge CLOCK);
    checkOutput("post_reset_idle", busOut(), 64'd0);

    checkOutput("bus_q_empty", 64'(bus_q.size()), 64'd0);
    checkOutput("status_q_empty", 64'(status_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
